// File: rtl/redux_multiciclo.sv
// redux_multiciclo -- multi-cycle Redux-V CPU core.
//
// Same 8-bit instruction format and four-register file as the single-cycle
// Redux-V, with a generic data width and external instruction/data memories
// reached through req/ack handshakes. Controlled by a FETCH/EXEC/MEM/HALT FSM.
//
// Handshake (both memory ports): req is driven combinationally from the FSM
// state and is high exactly in FETCH (imem) or MEM (dmem) while rst=0. Address,
// we and wdata stay stable while req is high. The memory completes the access
// by raising ack for one cycle (same cycle as req for zero wait states); the
// core consumes rdata in that cycle and drops req in the next. An ack seen
// while the matching req is low is ignored.
//
// Parameters:
//   DATA_W  register/ALU/data word width (8..32)
//   ADDR_W  pc and memory address width (4..16)
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   imem_req/addr/ack/rdata  instruction fetch port (addr = pc)
//   dmem_req/we/addr/wdata/ack/rdata  data port (addr = R[rb], wdata = R[ra])
//   pc                       address of the instruction in flight
//   halted                   high while the FSM is in HALT
//   fsm_state                current FSM state (0 FETCH, 1 EXEC, 2 MEM, 3 HALT)
//
// Optional feature, macro REDUX_PERF_EN: adds saturating 32-bit counters
//   ciclos      +1 every non-reset cycle while not halted
//   instrucoes  +1 per completed instruction (HALT included)

module redux_multiciclo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [1:0]        fsm_state
`ifdef REDUX_PERF_EN
  ,
  output logic [31:0]       ciclos,
  output logic [31:0]       instrucoes
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_BRZR = 4'd0;
  localparam logic [3:0] OP_JI   = 4'd1;
  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_ST   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_ADD  = 4'd9;
  localparam logic [3:0] OP_SUB  = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12;
  localparam logic [3:0] OP_MOVI = 4'd13;
  localparam logic [3:0] OP_HALT = 4'd14;
  localparam logic [3:0] OP_NOP  = 4'd15;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc;
  logic [7:0]          ir_q, ir_d;
  logic [DATA_W-1:0]   rf [4];

  logic [3:0]          op;
  logic [1:0]          ra, rb;
  logic [3:0]          imm;
  logic signed [3:0]   imm_s;
  logic [DATA_W-1:0]   rf_a, rf_b;
  logic [DATA_W-1:0]   sext_d;
  logic [ADDR_W-1:0]   sext_a;
  logic [4:0]          shamt;
  logic [DATA_W-1:0]   alu_res;

  logic                rf_we;
  logic [1:0]          rf_widx;
  logic [DATA_W-1:0]   rf_wdata;

  // Decode fields always come from IR; IR only changes on a fetch ack.
  assign op     = ir_q[7:4];
  assign ra     = ir_q[3:2];
  assign rb     = ir_q[1:0];
  assign imm    = ir_q[3:0];
  assign imm_s  = ir_q[3:0];
  assign rf_a   = rf[ra];
  assign rf_b   = rf[rb];
  // Signed size casts sign-extend the 4-bit immediate.
  assign sext_d = DATA_W'(imm_s);
  assign sext_a = ADDR_W'(imm_s);
  // Shift distance is R[rb] mod DATA_W (DATA_W need not be a power of two).
  assign shamt  = 5'(rf_b % DATA_W);
  assign pc_inc = pc_q + 1'b1;

  assign imem_addr  = pc_q;
  // Register value truncated or zero-extended to the address width.
  assign dmem_addr  = ADDR_W'(rf_b);
  assign dmem_wdata = rf_a;
  assign pc         = pc_q;
  assign halted     = (state_q == ST_HALT);
  assign fsm_state  = state_q;

  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ADDI: alu_res = rf[0] + sext_d;
      OP_NOT:  alu_res = ~rf_b;
      OP_AND:  alu_res = rf_a & rf_b;
      OP_OR:   alu_res = rf_a | rf_b;
      OP_XOR:  alu_res = rf_a ^ rf_b;
      OP_ADD:  alu_res = rf_a + rf_b;
      OP_SUB:  alu_res = rf_a - rf_b;
      OP_SHL:  alu_res = rf_a << shamt;
      OP_SHR:  alu_res = rf_a >> shamt;
      OP_MOVI: alu_res = DATA_W'(imm);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    rf_we    = 1'b0;
    rf_widx  = ra;
    rf_wdata = alu_res;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        unique case (op)
          OP_LD, OP_ST: begin
            // pc advances only once the data access completes.
            state_d = ST_MEM;
            pc_d    = pc_q;
          end
          OP_HALT: begin
            state_d = ST_HALT;
            pc_d    = pc_q;
          end
          OP_BRZR: begin
            if (rf_a == '0) pc_d = ADDR_W'(rf_b);
          end
          OP_JI:   pc_d = pc_q + sext_a;
          OP_NOP:  ;
          OP_ADDI, OP_MOVI: begin
            rf_we   = 1'b1;
            rf_widx = 2'd0;
          end
          default: rf_we = 1'b1;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_ST);
        if (dmem_ack) begin
          if (op == OP_LD) begin
            rf_we    = 1'b1;
            rf_wdata = dmem_rdata;
          end
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: ;
    endcase

    // Requests drop in the very cycle reset is asserted.
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= 8'hF0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      if (rf_we) rf[rf_widx] <= rf_wdata;
    end
  end

`ifdef REDUX_PERF_EN
  logic instr_done;

  // An instruction completes in EXEC unless it needs the data port, in which
  // case it completes on the data ack.
  assign instr_done = ((state_q == ST_EXEC) && (op != OP_LD) && (op != OP_ST)) ||
                      ((state_q == ST_MEM) && dmem_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      ciclos     <= '0;
      instrucoes <= '0;
    end else begin
      if (!halted && (ciclos != '1)) ciclos <= ciclos + 1'b1;
      if (instr_done && (instrucoes != '1)) instrucoes <= instrucoes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_redux_multiciclo.sv
// tb_redux_multiciclo -- self-checking bench for redux_multiciclo.
//
// Two cores: u_dut (DATA_W=8, ADDR_W=8) with wait-state memories, and u_w
// (DATA_W=16, ADDR_W=4) with zero-wait memories. Every completed data access
// is compared against a queue of expected accesses; pc, halted and timing are
// checked directly. Counter checks apply when REDUX_PERF_EN is defined.

module tb_redux_multiciclo;

  logic clk = 1'b0;
  logic rst;
  logic rst_w;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Access record: {len, we, addr, data}; data is zero for loads.
  function automatic logic [63:0] mk(input int len, input logic we, input int addr, input int data);
    return {16'(len), 15'd0, we, 16'(addr), 16'(data)};
  endfunction

  logic [63:0] exp_q[$];
  logic [63:0] exp_w_q[$];

  // ---------------- main core: 8-bit data, 8-bit address ----------------
  logic       imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
  logic [7:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;
  logic [1:0] fsm_state;
`ifdef REDUX_PERF_EN
  logic [31:0] ciclos, instrucoes;
`endif

  logic [7:0] imem [256];
  logic [7:0] dmem [256];
  int imem_wait = 0;
  int dmem_wait = 0;
  int iw_cnt = 0;
  int dw_cnt = 0;
  logic dmem_force_ack = 1'b0;

  assign imem_ack   = imem_req && (iw_cnt == imem_wait);
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = (dmem_req && (dw_cnt == dmem_wait)) || dmem_force_ack;
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    iw_cnt <= (imem_req && !imem_ack) ? iw_cnt + 1 : 0;
    dw_cnt <= (dmem_req && !dmem_ack) ? dw_cnt + 1 : 0;
  end

  redux_multiciclo #(.DATA_W(8), .ADDR_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .halted(halted), .fsm_state(fsm_state)
`ifdef REDUX_PERF_EN
    , .ciclos(ciclos), .instrucoes(instrucoes)
`endif
  );

  // Data-access monitor: length, stability and content of each access.
  int          acc_len = 0;
  logic        acc_active = 1'b0;
  logic [63:0] acc_first;
  always @(negedge clk) begin
    if (dmem_req) begin
      if (!acc_active) begin
        acc_first  = mk(0, dmem_we, dmem_addr, dmem_we ? dmem_wdata : 8'd0);
        acc_len    = 0;
        acc_active = 1'b1;
      end
      acc_len++;
      if (dmem_ack) begin
        check("dmem_stable", mk(0, dmem_we, dmem_addr, dmem_we ? dmem_wdata : 8'd0), acc_first);
        if (exp_q.size() == 0) check("dmem_extra_access", 64'(exp_q.size()), 64'd1);
        else check("dmem_access", mk(acc_len, dmem_we, dmem_addr, dmem_we ? dmem_wdata : 8'd0),
                   exp_q.pop_front());
        if (dmem_we) dmem[dmem_addr] = dmem_wdata;
        acc_active = 1'b0;
      end
    end else begin
      acc_active = 1'b0;
    end
  end

  // Fetch address must hold while a fetch waits.
  logic       prev_ireq = 1'b0;
  logic       prev_iack = 1'b0;
  logic [7:0] prev_iaddr = '0;
  always @(negedge clk) begin
    if (imem_req && prev_ireq && !prev_iack) check("fetch_addr_stable", imem_addr, prev_iaddr);
    prev_ireq  = imem_req;
    prev_iack  = imem_ack;
    prev_iaddr = imem_addr;
  end

  // ---------------- wide core: 16-bit data, 4-bit address ----------------
  logic        imem_req_w, dmem_req_w, dmem_we_w, halted_w;
  logic [3:0]  imem_addr_w, dmem_addr_w, pc_w;
  logic [7:0]  imem_rdata_w;
  logic [15:0] dmem_wdata_w, dmem_rdata_w;
  logic [1:0]  fsm_state_w;
`ifdef REDUX_PERF_EN
  logic [31:0] ciclos_w, instrucoes_w;
`endif
  logic [7:0]  imem_w [16];
  logic [15:0] dmem_w [16];

  assign imem_rdata_w = imem_w[imem_addr_w];
  assign dmem_rdata_w = dmem_w[dmem_addr_w];

  redux_multiciclo #(.DATA_W(16), .ADDR_W(4)) u_w (
    .clk(clk), .rst(rst_w),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_req_w), .imem_rdata(imem_rdata_w),
    .dmem_req(dmem_req_w), .dmem_we(dmem_we_w), .dmem_addr(dmem_addr_w), .dmem_wdata(dmem_wdata_w),
    .dmem_ack(dmem_req_w), .dmem_rdata(dmem_rdata_w),
    .pc(pc_w), .halted(halted_w), .fsm_state(fsm_state_w)
`ifdef REDUX_PERF_EN
    , .ciclos(ciclos_w), .instrucoes(instrucoes_w)
`endif
  );

  always @(negedge clk) begin
    if (dmem_req_w) begin
      if (exp_w_q.size() == 0) check("w_dmem_extra_access", 64'(exp_w_q.size()), 64'd1);
      else check("w_dmem_access", mk(1, dmem_we_w, dmem_addr_w, dmem_we_w ? dmem_wdata_w : 16'd0),
                 exp_w_q.pop_front());
      if (dmem_we_w) dmem_w[dmem_addr_w] = dmem_wdata_w;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 8'hE0;   // HALT everywhere: a wrong jump stops at a wrong pc
      dmem[i] = 8'h00;
    end
  endtask

  task automatic wait_halt(input string tag, input int limit, output int cyc);
    cyc = 0;
    while (!halted && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, halted, 1'b1);
  endtask

  int cyc;

  initial begin
    rst   = 1'b1;
    rst_w = 1'b1;

    // Phase 1: reset, first fetch, ALU program, zero wait states.
    clear_mem();
    imem[0]  = 8'h30;  // ST R0,R0  -> M[0]=0
    imem[1]  = 8'h34;  // ST R1,R0
    imem[2]  = 8'h38;  // ST R2,R0
    imem[3]  = 8'h3C;  // ST R3,R0
    imem[4]  = 8'hD7;  // MOVI 7      R0=7
    imem[5]  = 8'h94;  // ADD R1,R0   R1=7
    imem[6]  = 8'h34;  // ST R1,R0 -> M[7]=7
    imem[7]  = 8'hA4;  // SUB R1,R0   R1=0
    imem[8]  = 8'h34;  // ST R1,R0 -> M[7]=0
    imem[9]  = 8'h4F;  // ADDI -1     R0=6
    imem[10] = 8'h31;  // ST R0,R1 -> M[0]=6
    imem[11] = 8'hE0;  // HALT
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, 1'b1, 0, 0));
    exp_q.push_back(mk(1, 1'b1, 7, 7));
    exp_q.push_back(mk(1, 1'b1, 7, 0));
    exp_q.push_back(mk(1, 1'b1, 0, 6));

    for (int i = 0; i < 16; i++) begin
      imem_w[i] = 8'hE0;
      dmem_w[i] = 16'h0000;
    end
    imem_w[0]  = 8'h1E;  // JI -2   -> 14
    imem_w[14] = 8'hF0;  // NOP
    imem_w[15] = 8'h12;  // JI +2   -> 1 (wraps)
    imem_w[1]  = 8'hD1;  // MOVI 1     R0=1
    imem_w[2]  = 8'h24;  // LD R1,R0   R1=M[1]=17
    imem_w[3]  = 8'h22;  // LD R0,R2   R0=M[0]=8001
    imem_w[4]  = 8'hB1;  // SHL R0,R1  shift by 17 mod 16 = 1
    imem_w[5]  = 8'h32;  // ST R0,R2 -> M[0]=0002
    imem_w[6]  = 8'hE0;  // HALT
    dmem_w[0]  = 16'h8001;
    dmem_w[1]  = 16'd17;
    exp_w_q.push_back(mk(1, 1'b0, 1, 0));
    exp_w_q.push_back(mk(1, 1'b0, 0, 0));
    exp_w_q.push_back(mk(1, 1'b1, 0, 16'h0002));

    repeat (3) @(negedge clk);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_dmem_we", dmem_we, 1'b0);
    check("rst_pc", pc, 8'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_state", fsm_state, 2'd0);
`ifdef REDUX_PERF_EN
    check("rst_ciclos", ciclos, 32'd0);
    check("rst_instrucoes", instrucoes, 32'd0);
`endif
    rst   = 1'b0;
    rst_w = 1'b0;
    #1;
    check("first_fetch_req", imem_req, 1'b1);
    check("first_fetch_addr", imem_addr, 8'd0);
    wait_halt("p1_halt", 200, cyc);
    check("p1_cycles", cyc, 31);
    check("p1_pc", pc, 8'd11);
    check("p1_queue_empty", exp_q.size(), 0);
`ifdef REDUX_PERF_EN
    check("p1_ciclos", ciclos, 32'd31);
    check("p1_instrucoes", instrucoes, 32'd12);
`endif
    repeat (3) @(negedge clk);
    check("halt_pc_hold", pc, 8'd11);
    check("halt_hold", halted, 1'b1);
    check("halt_no_imem_req", imem_req, 1'b0);
    check("halt_no_dmem_req", dmem_req, 1'b0);
    check("w_halted", halted_w, 1'b1);
    check("w_pc", pc_w, 4'd6);
    check("w_queue_empty", exp_w_q.size(), 0);

    // Phase 2: wait states, load/store, branches, pc wrap, remaining ALU ops.
    rst = 1'b1;
    imem_wait = 1;
    dmem_wait = 2;
    clear_mem();
    imem[0]   = 8'h1E;  // JI -2     -> 254
    imem[254] = 8'h14;  // JI +4     -> 2 (wraps)
    imem[2]   = 8'hD3;  // MOVI 3      R0=3
    imem[3]   = 8'h94;  // ADD R1,R0   R1=3
    imem[4]   = 8'hD5;  // MOVI 5      R0=5
    imem[5]   = 8'h31;  // ST R0,R1 -> M[3]=5
    imem[6]   = 8'h29;  // LD R2,R1    R2=5
    imem[7]   = 8'h3B;  // ST R2,R3 -> M[0]=5
    imem[8]   = 8'hDB;  // MOVI 11     R0=11
    imem[9]   = 8'h0C;  // BRZR R3,R0  taken -> 11
    imem[11]  = 8'h01;  // BRZR R0,R1  not taken -> 12
    imem[12]  = 8'hD0;  // MOVI 0
    imem[13]  = 8'h4F;  // ADDI -1     R0=FF
    imem[14]  = 8'h33;  // ST R0,R3 -> M[0]=FF
    imem[15]  = 8'h5D;  // NOT R3,R1   R3=FC
    imem[16]  = 8'h3D;  // ST R3,R1 -> M[3]=FC
    imem[17]  = 8'h6E;  // AND R3,R2   R3=04
    imem[18]  = 8'h7D;  // OR  R3,R1   R3=07
    imem[19]  = 8'h8E;  // XOR R3,R2   R3=02
    imem[20]  = 8'hBD;  // SHL R3,R1   R3=10
    imem[21]  = 8'hC1;  // SHR R0,R1   R0=1F
    imem[22]  = 8'h3D;  // ST R3,R1 -> M[3]=10
    imem[23]  = 8'h31;  // ST R0,R1 -> M[3]=1F
    imem[24]  = 8'hF0;  // NOP
    imem[25]  = 8'hE0;  // HALT
    exp_q.delete();
    exp_q.push_back(mk(3, 1'b1, 3, 8'h05));
    exp_q.push_back(mk(3, 1'b0, 3, 0));
    exp_q.push_back(mk(3, 1'b1, 0, 8'h05));
    exp_q.push_back(mk(3, 1'b1, 0, 8'hFF));
    exp_q.push_back(mk(3, 1'b1, 3, 8'hFC));
    exp_q.push_back(mk(3, 1'b1, 3, 8'h10));
    exp_q.push_back(mk(3, 1'b1, 3, 8'h1F));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_halt("p2_halt", 1000, cyc);
    check("p2_pc", pc, 8'd25);
    check("p2_state", fsm_state, 2'd3);
    check("p2_queue_empty", exp_q.size(), 0);

    // Phase 3: reset in the middle of a data access, late ack ignored.
    rst = 1'b1;
    imem_wait = 0;
    dmem_wait = 15;
    clear_mem();
    imem[0] = 8'h24;    // LD R1,R0 (stalls, then aborted by reset)
    dmem[0] = 8'h5A;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (!dmem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_mem_req", dmem_req, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_dmem_req", dmem_req, 1'b0);
    check("mid_rst_imem_req", imem_req, 1'b0);
    check("mid_rst_dmem_we", dmem_we, 1'b0);
    @(negedge clk);
    dmem_force_ack = 1'b1;
    dmem_wait = 1;
    imem[0] = 8'h34;    // ST R1,R0 -> M[0]=0
    imem[1] = 8'hE0;    // HALT
    exp_q.push_back(mk(2, 1'b1, 0, 0));
    @(negedge clk);
    rst = 1'b0;         // stray ack still high during the first FETCH
    #1;
    check("p3_fetch_req", imem_req, 1'b1);
    check("p3_fetch_addr", imem_addr, 8'd0);
    check("p3_pc", pc, 8'd0);
    check("p3_halted", halted, 1'b0);
`ifdef REDUX_PERF_EN
    check("p3_ciclos", ciclos, 32'd0);
    check("p3_instrucoes", instrucoes, 32'd0);
`endif
    @(negedge clk);
    dmem_force_ack = 1'b0;
    wait_halt("p3_halt", 100, cyc);
    check("p3_halt_pc", pc, 8'd1);
    check("p3_queue_empty", exp_q.size(), 0);
`ifdef REDUX_PERF_EN
    check("p3_ciclos_final", ciclos, 32'd6);
    check("p3_instrucoes_final", instrucoes, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
